// File: rtl/keypad_digit_buffer.sv
// Keypad entry: priority-encodes key lines, debounces one digit per press,
// and keeps a shift-register digit buffer with backspace/clear/lock.
module keypad_digit_buffer #(
  parameter int NUM_KEYS = 10,
  parameter int DIGITS   = 4,
  parameter int DIGIT_W  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         key_in,
  input  logic                        bksp,
  input  logic                        clr,
  input  logic                        lock,
  output logic [DIGITS*DIGIT_W-1:0]   digits_out,
  output logic [$clog2(DIGITS+1)-1:0] count,
  output logic                        empty,
  output logic                        full,
  output logic                        key_valid,
  output logic [DIGIT_W-1:0]          key_code,
  output logic                        overflow
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int SW = DIGITS * DIGIT_W;

  typedef enum logic {
    IDLE,
    HELD
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     digits_q, digits_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DIGIT_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  logic [DIGIT_W-1:0] enc;
  logic               any_key;
  logic               press_ev;
  logic               is_full;
  logic               is_empty;

  always_comb begin
    enc = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (key_in[k]) enc = DIGIT_W'(k);
    end
  end

  assign any_key  = |key_in;
  assign is_full  = (count_q == CW'(DIGITS));
  assign is_empty = (count_q == '0);
  assign press_ev = (state_q == IDLE) && any_key;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_key)  state_d = HELD;
      HELD:    if (!any_key) state_d = IDLE;
      default: state_d = HELD;
    endcase
  end

  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    if (clr) begin
      digits_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else if (bksp && !lock) begin
      // a press landing with bksp is swallowed here
      if (!is_empty) begin
        digits_d = {DIGIT_W'(0), digits_q[SW-1:DIGIT_W]};
        count_d  = count_q - CW'(1);
      end
    end else if (press_ev && !lock) begin
      if (is_full) begin
        ovf_d = 1'b1;
      end else begin
        digits_d = {digits_q[SW-DIGIT_W-1:0], enc};
        count_d  = count_q + CW'(1);
        code_d   = enc;
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HELD;
      digits_q <= '0;
      count_q  <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign digits_out = digits_q;
  assign count      = count_q;
  assign empty      = is_empty;
  assign full       = is_full;
  assign key_valid  = valid_q;
  assign key_code   = code_q;
  assign overflow   = ovf_q;

endmodule
